dut_sweep_sequencer: RTL

- Self-test controller for the two-stage logic datapath (stage A output feeding stage B) on the switch/LED board.
- Replaces the manual switches: steps through every input vector, waits a settle window, and samples the datapath result.
- Compares each sampled result against a golden model result, then reports pass/fail, an error count and the first failing vector.
- Sits between the top level and the datapath; the top level muxes between switch input and `vec`.

---
 rtl/dut_sweep_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dut_sweep_sequencer.sv
// Self-test sequencer: steps every input vector through the two-stage datapath,
// waits a settle window, then compares the sampled result with the golden model.
module dut_sweep_sequencer #(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       result,
  input  logic [1:0]       golden,
  output logic [WIDTH-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_vec,
  output logic             fail_valid
);

  localparam int unsigned      SET_W    = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] VEC_LAST = '1;
  localparam bit               STOP_EN  = (STOP_ON_FAIL != 0);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_vec, w_vec_nxt;
  logic [SET_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_err, w_err_nxt;
  logic [WIDTH-1:0] r_fail_vec, w_fail_vec_nxt;
  logic             r_fail_valid, w_fail_valid_nxt;
  logic             r_busy, r_done, r_pass;
  logic             w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic             w_mismatch;

  assign w_mismatch = (result != golden);

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_fail_vec   <= w_fail_vec_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_fail_vec_nxt   = r_fail_vec;
    w_fail_valid_nxt = r_fail_valid;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt      = S_SETTLE;
          w_vec_nxt        = '0;
          w_cnt_nxt        = '0;
          w_err_nxt        = '0;
          w_fail_vec_nxt   = '0;
          w_fail_valid_nxt = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == SET_LAST) w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        // abort outranks the compare, so the aborted vector is never counted
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          if (w_mismatch) begin
            if (r_err != '1) w_err_nxt = r_err + 1'b1;
            if (!r_fail_valid) begin
              w_fail_vec_nxt   = r_vec;
              w_fail_valid_nxt = 1'b1;
            end
          end
          if ((r_vec == VEC_LAST) || (STOP_EN && w_mismatch)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_vec_nxt   = r_vec + 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SETTLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CHECK);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
  end

  assign vec        = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule
